// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the PLRU victim allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_repl_pkg;

    localparam int WAYS     = 8;
    localparam int SET_BITS = 7;
    localparam int SETS     = 1 << SET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        OFFER,
        FILL,
        UPDATE
    } alloc_state_t;

    // Isolate the lowest set bit; an all-zero vector maps to way 0 so a
    // broken or idle PLRU flag still yields a legal one-hot way.
    function automatic logic [WAYS-1:0] onehot_lowest(input logic [WAYS-1:0] vec);
        logic [WAYS-1:0] res;
        res = vec & (~vec + WAYS'(1));
        if (vec == '0) begin
            res = WAYS'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/lru_victim_alloc_if.sv
// Miss request / victim offer / fill-done channel between the cache miss path and the allocator.
// Latency: n/a (wiring only).
// Backpressure: miss uses valid/ready, victim offer uses valid/ready, fill_done is a pulse.
interface lru_victim_alloc_if;
    import cache_repl_pkg::*;

    logic                i_miss_valid;
    logic                o_miss_ready;
    logic [SET_BITS-1:0] i_miss_addr_7;
    logic                o_victim_valid;
    logic                i_victim_ready;
    logic [WAYS-1:0]     o_victim_way_8;
    logic [SET_BITS-1:0] o_victim_addr_7;
    logic                o_victim_evict;
    logic                i_fill_done;

    // Allocator side
    modport slave (
        input  i_miss_valid, i_miss_addr_7, i_victim_ready, i_fill_done,
        output o_miss_ready, o_victim_valid, o_victim_way_8, o_victim_addr_7, o_victim_evict
    );

    // Miss path / refill controller side
    modport master (
        output i_miss_valid, i_miss_addr_7, i_victim_ready, i_fill_done,
        input  o_miss_ready, o_victim_valid, o_victim_way_8, o_victim_addr_7, o_victim_evict
    );

endinterface

// File: rtl/way_pick_lowest.sv
// One-hot picker: lowest set bit of the input vector, zero input selects way 0.
// Latency: combinational.
// Backpressure: none.
module way_pick_lowest
    import cache_repl_pkg::*;
(
    input  logic [WAYS-1:0] vec_i,
    output logic [WAYS-1:0] pick_o
);

    assign pick_o = onehot_lowest(vec_i);

endmodule

// File: rtl/lru_victim_alloc.sv
// Miss-side victim allocator: prefers invalid ways, else PLRU flag; offers victim, then MRU-updates after fill.
// Latency: victim offered LRU_RD_LAT+1 cycles after miss accept; one UPDATE cycle after fill_done.
// Backpressure: miss accepted only in IDLE; victim held stable until i_victim_ready.
module lru_victim_alloc
    import cache_repl_pkg::*;
#(
    parameter int LRU_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    lru_victim_alloc_if.slave   bus,
    output logic [SET_BITS-1:0] o_lru_addr_7,
    output logic [WAYS-1:0]     o_lru_hit_way_8,
    output logic                o_lru_hit_sig,
    output logic                o_lru_own,
    input  logic [WAYS-1:0]     i_lru_flag_8,
    input  logic                i_inv_valid,
    input  logic [SET_BITS-1:0] i_inv_addr_7,
    input  logic [WAYS-1:0]     i_inv_way_8
);

    localparam logic [1:0] LAT_CNT = 2'(LRU_RD_LAT);

    alloc_state_t             state_q;
    logic [1:0]               lat_cnt_q;
    logic [SET_BITS-1:0]      set_q;
    logic [WAYS-1:0]          victim_q;
    logic                     evict_q;
    logic                     victim_vld_q;
    logic                     miss_rdy_q;
    logic                     own_q;
    logic                     hit_sig_q;
    logic [WAYS-1:0]          hit_way_q;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] valid_d;

    logic [WAYS-1:0]          set_invalid;
    logic [WAYS-1:0]          inv_pick;
    logic [WAYS-1:0]          flag_pick;
    logic                     fill_fire;

    assign set_invalid = ~valid_q[set_q];
    assign fill_fire   = (state_q == FILL) && bus.i_fill_done;

    way_pick_lowest u_pick_inv  (.vec_i(set_invalid),  .pick_o(inv_pick));
    way_pick_lowest u_pick_flag (.vec_i(i_lru_flag_8), .pick_o(flag_pick));

    // Valid-bit next state: invalidate clears first, a completing refill sets afterwards so it wins.
    always_comb begin
        valid_d = valid_q;
        if (i_inv_valid) begin
            valid_d[i_inv_addr_7] = valid_d[i_inv_addr_7] & ~i_inv_way_8;
        end
        if (fill_fire) begin
            valid_d[set_q] = valid_d[set_q] | victim_q;
        end
    end

    // Valid-bit array; reset leaves every way invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Allocation FSM with all handshake and LRU-port outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            set_q        <= '0;
            victim_q     <= '0;
            evict_q      <= 1'b0;
            victim_vld_q <= 1'b0;
            miss_rdy_q   <= 1'b0;
            own_q        <= 1'b0;
            hit_sig_q    <= 1'b0;
            hit_way_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_miss_valid && miss_rdy_q) begin
                        set_q      <= bus.i_miss_addr_7;
                        lat_cnt_q  <= '0;
                        miss_rdy_q <= 1'b0;
                        own_q      <= 1'b1;
                        state_q    <= LOOKUP;
                    end else begin
                        miss_rdy_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    // The flag for set_q is trustworthy once the read latency has elapsed.
                    if (lat_cnt_q == LAT_CNT) begin
                        victim_q     <= (|set_invalid) ? inv_pick : flag_pick;
                        evict_q      <= ~(|set_invalid);
                        victim_vld_q <= 1'b1;
                        state_q      <= OFFER;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                OFFER: begin
                    if (bus.i_victim_ready) begin
                        victim_vld_q <= 1'b0;
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.i_fill_done) begin
                        hit_sig_q <= 1'b1;
                        hit_way_q <= victim_q;
                        state_q   <= UPDATE;
                    end
                end
                UPDATE: begin
                    hit_sig_q  <= 1'b0;
                    hit_way_q  <= '0;
                    own_q      <= 1'b0;
                    miss_rdy_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_miss_ready    = miss_rdy_q;
    assign bus.o_victim_valid  = victim_vld_q;
    assign bus.o_victim_way_8  = victim_q;
    assign bus.o_victim_addr_7 = set_q;
    assign bus.o_victim_evict  = evict_q;
    assign o_lru_addr_7        = set_q;
    assign o_lru_hit_way_8     = hit_way_q;
    assign o_lru_hit_sig       = hit_sig_q;
    assign o_lru_own           = own_q;

endmodule

// File: tb/tb_lru_victim_alloc.sv
// Bench for lru_victim_alloc paired with a behavioural tree-PLRU buffer stand-in.
// Latency: PLRU flag registered one cycle after the address (LRU_RD_LAT=1).
// Backpressure: bench drives victim_ready holds and delayed fill_done.
`timescale 1ns/1ps
module tb_lru_victim_alloc;
    import cache_repl_pkg::*;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lru_victim_alloc_if bus();

    logic [SET_BITS-1:0] lru_addr;
    logic [WAYS-1:0]     lru_hit_way;
    logic                lru_hit_sig;
    logic                lru_own;
    logic [WAYS-1:0]     lru_flag;
    logic                inv_vld;
    logic [SET_BITS-1:0] inv_addr;
    logic [WAYS-1:0]     inv_way;

    lru_victim_alloc #(.LRU_RD_LAT(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .o_lru_addr_7    (lru_addr),
        .o_lru_hit_way_8 (lru_hit_way),
        .o_lru_hit_sig   (lru_hit_sig),
        .o_lru_own       (lru_own),
        .i_lru_flag_8    (lru_flag),
        .i_inv_valid     (inv_vld),
        .i_inv_addr_7    (inv_addr),
        .i_inv_way_8     (inv_way)
    );

    // ---------------- tree-PLRU buffer stand-in ----------------
    bit [6:0] tree [SETS];

    function automatic int plru_way(input bit [6:0] t);
        int node = 0;
        for (int l = 0; l < 3; l++) node = 2 * node + 1 + int'(t[node]);
        return node - 7;
    endfunction

    function automatic bit [6:0] plru_touch(input bit [6:0] t, input int w);
        int node = 0;
        int d;
        for (int l = 0; l < 3; l++) begin
            d = (w >> (2 - l)) & 1;
            t[node] = ~d[0];
            node = 2 * node + 1 + d;
        end
        return t;
    endfunction

    function automatic int way_idx(input logic [7:0] oh);
        int r = 0;
        for (int i = 7; i >= 0; i--) if (oh[i]) r = i;
        return r;
    endfunction

    // Registered PLRU read plus MRU update on hit, as LRU_buffer does.
    always @(posedge clk) begin
        lru_flag <= 8'(1) << plru_way(tree[lru_addr]);
        if (lru_hit_sig) tree[lru_addr] <= plru_touch(tree[lru_addr], way_idx(lru_hit_way));
    end

    int hit_cnt = 0;
    always @(posedge clk) if (lru_hit_sig) hit_cnt++;

    // ---------------- reference model ----------------
    bit [7:0] mvalid [SETS];
    bit [7:0] mru    [SETS];

    function automatic void expect_pick(input int s, output logic [7:0] w, output logic ev);
        w  = '0;
        ev = 1'b1;
        for (int i = 7; i >= 0; i--) if (!mvalid[s][i]) begin w = 8'(1) << i; ev = 1'b0; end
        if (ev) w = 8'(1) << plru_way(tree[s]);
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction helpers (negedge aligned) ----------------
    task automatic start_miss(input int s);
        int n = 0;
        while (bus.o_miss_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("miss_ready_wait", 32'(bus.o_miss_ready), 1);
        bus.i_miss_valid  = 1'b1;
        bus.i_miss_addr_7 = 7'(s);
        @(negedge clk);
        bus.i_miss_valid  = 1'b0;
    endtask

    task automatic wait_offer(input int s, input int cyc0, output logic [7:0] w, output logic ev);
        int cyc = cyc0;
        while (bus.o_victim_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("offer_latency", cyc, LAT + 1);
        expect_pick(s, w, ev);
        chk("victim_way", bus.o_victim_way_8, w);
        chk("victim_evict", 32'(bus.o_victim_evict), 32'(ev));
        chk("victim_addr", bus.o_victim_addr_7, s);
        chk("lru_own", 32'(lru_own), 1);
        if (ev) begin
            chk("victim_is_flag", bus.o_victim_way_8, lru_flag);
            chk("victim_not_mru", 32'(bus.o_victim_way_8 == mru[s]), 0);
        end
    endtask

    task automatic accept(input logic [7:0] w, input logic ev, input int s, input int hold);
        bus.i_victim_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.i_miss_valid  = 1'b1;
            bus.i_miss_addr_7 = 7'(s + 1);
            @(negedge clk);
            chk("offer_stable", {bus.o_victim_valid, bus.o_victim_evict, bus.o_victim_addr_7, bus.o_victim_way_8},
                {1'b1, ev, 7'(s), w});
            chk("offer_miss_ready", 32'(bus.o_miss_ready), 0);
        end
        bus.i_miss_valid   = 1'b0;
        bus.i_victim_ready = 1'b1;
        @(negedge clk);
        bus.i_victim_ready = 1'b0;
        chk("fill_entry", {bus.o_victim_valid, bus.o_miss_ready, lru_hit_sig}, 0);
    endtask

    task automatic finish_fill(input int s, input logic [7:0] w, input int delay, input bit inv_same);
        for (int i = 0; i < delay; i++) begin
            bus.i_miss_valid = 1'b1;
            @(negedge clk);
            chk("fill_wait", {lru_hit_sig, bus.o_miss_ready}, 0);
        end
        bus.i_miss_valid = 1'b0;
        bus.i_fill_done  = 1'b1;
        if (inv_same) begin inv_vld = 1'b1; inv_addr = 7'(s); inv_way = w; end
        @(negedge clk);
        bus.i_fill_done = 1'b0;
        inv_vld         = 1'b0;
        mvalid[s]       = mvalid[s] | w;
        mru[s]          = w;
        chk("update_pulse", {lru_hit_sig, lru_hit_way, lru_addr}, {1'b1, w, 7'(s)});
        @(negedge clk);
        chk("update_end", {lru_hit_sig, lru_hit_way, bus.o_miss_ready, lru_own}, {1'b0, 8'h00, 1'b1, 1'b0});
    endtask

    task automatic inv_pulse(input int s, input logic [7:0] w);
        inv_vld  = 1'b1;
        inv_addr = 7'(s);
        inv_way  = w;
        @(negedge clk);
        inv_vld   = 1'b0;
        mvalid[s] = mvalid[s] & ~w;
    endtask

    task automatic do_txn(input int s, input int hold, input int delay, input bit inv_same,
                          output logic [7:0] w);
        logic ev;
        start_miss(s);
        wait_offer(s, 0, w, ev);
        accept(w, ev, s, hold);
        finish_fill(s, w, delay, inv_same);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] inv_way;
        int         set;
        logic [7:0] exp_way;
        logic       exp_ev;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [7:0] iw, input int s, input logic [7:0] ew, input logic ev);
        vec_t v;
        v.inv_way = iw; v.set = s; v.exp_way = ew; v.exp_ev = ev;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic       ev;
        int         h0;

        rst = 1'b1;
        bus.i_miss_valid = 1'b0; bus.i_miss_addr_7 = '0;
        bus.i_victim_ready = 1'b0; bus.i_fill_done = 1'b0;
        inv_vld = 1'b0; inv_addr = '0; inv_way = '0;
        #1 rst = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.o_miss_ready, bus.o_victim_valid, bus.o_victim_way_8, bus.o_victim_addr_7,
                              bus.o_victim_evict, lru_addr, lru_hit_way, lru_hit_sig, lru_own}, 0);
        rst = 1'b1;
        #1 chk("ready_low_at_release", 32'(bus.o_miss_ready), 0);
        @(negedge clk);
        chk("ready_after_release", 32'(bus.o_miss_ready), 1);

        // Table: first miss, fill set 12 completely, PLRU eviction, fill set 13, invalidate-then-miss
        add(8'h00, 13, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) add(8'h00, 12, 8'(1) << i, 1'b0);
        add(8'h00, 12, 8'h01, 1'b1);
        for (int i = 1; i < 8; i++) add(8'h00, 13, 8'(1) << i, 1'b0);
        add(8'h20, 13, 8'h20, 1'b0);

        foreach (vecs[k]) begin
            if (vecs[k].inv_way != 8'h00) inv_pulse(vecs[k].set, vecs[k].inv_way);
            start_miss(vecs[k].set);
            wait_offer(vecs[k].set, 0, w, ev);
            chk("tbl_way", bus.o_victim_way_8, vecs[k].exp_way);
            chk("tbl_evict", 32'(bus.o_victim_evict), 32'(vecs[k].exp_ev));
            accept(w, ev, vecs[k].set, 0);
            finish_fill(vecs[k].set, w, 0, 1'b0);
        end

        // Long ready stall and busy miss requests on a full set
        do_txn(13, 5, 3, 1'b0, w);

        // fill_done and invalidate of the same way in one cycle: fill wins
        do_txn(40, 0, 1, 1'b1, w);
        do_txn(40, 0, 0, 1'b0, w);
        chk("fill_wins_next_way", w, 8'h02);

        // Invalidate during LOOKUP is seen; after the pick it is not
        start_miss(13);
        inv_pulse(13, 8'h08);
        wait_offer(13, 1, w, ev);
        chk("lookup_inv_way", w, 8'h08);
        inv_pulse(13, 8'h02);
        accept(w, ev, 13, 2);
        finish_fill(13, w, 0, 1'b0);

        // Reset during FILL aborts without an UPDATE pulse
        start_miss(70);
        wait_offer(70, 0, w, ev);
        accept(w, ev, 70, 0);
        h0 = hit_cnt;
        rst = 1'b0;
        bus.i_fill_done = 1'b1;
        #1 chk("midreset_outputs", {bus.o_miss_ready, bus.o_victim_valid, bus.o_victim_way_8, bus.o_victim_addr_7,
                                    bus.o_victim_evict, lru_addr, lru_hit_way, lru_hit_sig, lru_own}, 0);
        @(negedge clk);
        @(negedge clk);
        bus.i_fill_done = 1'b0;
        rst = 1'b1;
        for (int s = 0; s < SETS; s++) mvalid[s] = 8'h00;
        @(negedge clk);
        chk("midreset_no_hit", hit_cnt - h0, 0);
        chk("midreset_ready", 32'(bus.o_miss_ready), 1);
        do_txn(70, 1, 1, 1'b0, w);
        chk("post_reset_way", w, 8'h01);

        // Randomized traffic on a few sets so evictions and invalidates mix
        for (int n = 0; n < 40; n++) begin
            int s;
            s = 100 + int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) inv_pulse(s, 8'($urandom));
            do_txn(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
